// File: rtl/riscv_core_mul_div_unit.sv
// Sequential RV64M/RV32M execute unit: a shift-add multiplier and a restoring divider
// that retire BITS_PER_CYCLE bits per iteration, behind valid/ready handshakes with flush.
//
// state | meaning
// IDLE  | waiting for a request, o_mdu_ready high
// PREP  | take operand magnitudes, clear accumulator, resolve divide special cases
// CALC  | N iterations of multiply or divide
// FIX   | apply result signs, pick low/high half, sign-extend W forms
// DONE  | result held on o_mdu_valid until the consumer takes it
module riscv_core_mul_div_unit #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            i_mdu_clk,
  input  logic            i_mdu_rstn,
  input  logic            i_mdu_valid,
  output logic            o_mdu_ready,
  input  logic [2:0]      i_mdu_op,
  input  logic            i_mdu_isword,
  input  logic [XLEN-1:0] i_mdu_srcA,
  input  logic [XLEN-1:0] i_mdu_srcB,
  input  logic            i_mdu_flush,
  output logic            o_mdu_valid,
  input  logic            i_mdu_ready,
  output logic [XLEN-1:0] o_mdu_result
);
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int PW    = 2 * XLEN;
  localparam int PPW   = XLEN + BPC;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic              word_q;
  logic [XLEN-1:0]   ab_q;
  logic [XLEN-1:0]   b_q;
  logic [PW-1:0]     acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q;
  logic              sa_q;
  logic              valid_q;
  logic [XLEN-1:0]   result_q;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x, input logic w);
    logic [31:0] lo;
    lo = x[31:0];
    return w ? XLEN'($signed(lo)) : x;
  endfunction

  // ab_q carries srcA raw until PREP, then the aligned multiplier/dividend, finally the quotient.
  logic [XLEN-1:0] mask, min_w, a_w, b_w, a_mag, b_mag, a_align, special_res;
  logic            a_top, b_top, sgn_a_op, sgn_b_op, sa, sb, div_zero, div_ovf;
  logic [CNT_W-1:0] n_load;

  always_comb begin
    mask     = word_q ? XLEN'(32'hFFFF_FFFF) : '1;
    min_w    = (mask >> 1) + XLEN'(1);
    a_w      = ab_q & mask;
    b_w      = b_q & mask;
    a_top    = word_q ? ab_q[31] : ab_q[XLEN-1];
    b_top    = word_q ? b_q[31]  : b_q[XLEN-1];
    sgn_a_op = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
    sgn_b_op = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
    sa       = sgn_a_op && a_top;
    sb       = sgn_b_op && b_top;
    a_mag    = (sa ? -a_w : a_w) & mask;
    b_mag    = (sb ? -b_w : b_w) & mask;
    a_align  = word_q ? (a_mag << 32) : a_mag;
    n_load   = word_q ? CNT_W'(32 / BPC - 1) : CNT_W'(XLEN / BPC - 1);
    div_zero = op_q[2] && (b_w == '0);
    div_ovf  = op_q[2] && !op_q[0] && (a_w == min_w) && (b_w == mask);
    if (div_zero)
      special_res = op_q[1] ? sext_w(ab_q, word_q) : '1;
    else
      special_res = op_q[1] ? '0 : sext_w(min_w, word_q);
  end

  logic [PW-1:0]   acc_d;
  logic [XLEN-1:0] ab_d;
  logic [XLEN:0]   rem_t;
  logic [PPW-1:0]  pp;

  always_comb begin
    acc_d = acc_q;
    ab_d  = ab_q;
    rem_t = '0;
    pp    = '0;
    if (op_q[2]) begin
      for (int i = 0; i < BPC; i++) begin
        rem_t = {acc_d[XLEN-1:0], ab_d[XLEN-1]};
        ab_d  = ab_d << 1;
        if (rem_t >= {1'b0, b_q}) begin
          rem_t   = rem_t - {1'b0, b_q};
          ab_d[0] = 1'b1;
        end
        acc_d = PW'(rem_t);
      end
    end else begin
      // Multiplier digits are consumed MSB first, so the partial product shifts left.
      for (int j = 0; j < BPC; j++) begin
        if (ab_q[XLEN-BPC+j])
          pp = pp + (PPW'(b_q) << j);
      end
      acc_d = (acc_q << BPC) + PW'(pp);
      ab_d  = ab_q << BPC;
    end
  end

  logic [PW-1:0]   prod_s;
  logic [XLEN-1:0] mul_res, quo, rem, fix_res;

  always_comb begin
    prod_s  = neg_q ? -acc_q : acc_q;
    mul_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                   : XLEN'(word_q ? (prod_s >> 32) : (prod_s >> XLEN));
    quo     = neg_q ? -ab_q : ab_q;
    rem     = sa_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    fix_res = sext_w(op_q[2] ? (op_q[1] ? rem : quo) : mul_res, word_q);
  end

  always_ff @(posedge i_mdu_clk or negedge i_mdu_rstn) begin
    if (!i_mdu_rstn) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      word_q   <= 1'b0;
      ab_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (i_mdu_flush) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_mdu_valid) begin
            op_q    <= i_mdu_op;
            word_q  <= (XLEN > 32) ? i_mdu_isword : 1'b0;
            ab_q    <= i_mdu_srcA;
            b_q     <= i_mdu_srcB;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          ab_q  <= a_align;
          b_q   <= b_mag;
          acc_q <= '0;
          cnt_q <= n_load;
          neg_q <= sa ^ sb;
          sa_q  <= sa;
          if (div_zero || div_ovf) begin
            result_q <= special_res;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          ab_q  <= ab_d;
          if (cnt_q == '0)
            state_q <= S_FIX;
          else
            cnt_q <= cnt_q - CNT_W'(1);
        end
        S_FIX: begin
          result_q <= fix_res;
          valid_q  <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          if (i_mdu_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_mdu_ready  = (state_q == S_IDLE) && !i_mdu_flush;
  assign o_mdu_valid  = valid_q;
  assign o_mdu_result = result_q;

endmodule

// File: tb/tb_riscv_core_mul_div_unit.sv
// Directed and randomized checks of riscv_core_mul_div_unit (XLEN=64, BITS_PER_CYCLE=1)
// against a plain-arithmetic model of the RV64M semantics.
module tb_riscv_core_mul_div_unit;
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        valid_i = 1'b0, word_i = 1'b0, flush_i = 1'b0, rdy_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [63:0] a_i = '0, b_i = '0;
  logic        o_ready, o_valid;
  logic [63:0] o_result;
  int          n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  riscv_core_mul_div_unit #(.XLEN(64), .BITS_PER_CYCLE(1)) dut (
    .i_mdu_clk    (clk),
    .i_mdu_rstn   (rstn),
    .i_mdu_valid  (valid_i),
    .o_mdu_ready  (o_ready),
    .i_mdu_op     (op_i),
    .i_mdu_isword (word_i),
    .i_mdu_srcA   (a_i),
    .i_mdu_srcB   (b_i),
    .i_mdu_flush  (flush_i),
    .o_mdu_valid  (o_valid),
    .i_mdu_ready  (rdy_i),
    .o_mdu_result (o_result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] xa, xb, p;
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    a32 = a[31:0];
    b32 = b[31:0];
    r32 = '0;
    r   = '0;
    xa  = {{64{a[63] & (op == OP_MULH || op == OP_MULHSU)}}, a};
    xb  = {{64{b[63] & (op == OP_MULH)}}, b};
    p   = xa * xb;
    if (w) begin
      case (op)
        OP_DIV:
          if (b32 == 0) r32 = '1;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
          else r32 = $signed(a32) / $signed(b32);
        OP_DIVU: r32 = (b32 == 0) ? '1 : a32 / b32;
        OP_REM:
          if (b32 == 0) r32 = a32;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = '0;
          else r32 = $signed(a32) % $signed(b32);
        OP_REMU: r32 = (b32 == 0) ? a32 : a32 % b32;
        default: r32 = a32 * b32;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (op)
        OP_MUL: r = a * b;
        OP_DIV:
          if (b == 0) r = ONES;
          else if (a == MIN64 && b == ONES) r = MIN64;
          else r = $signed(a) / $signed(b);
        OP_DIVU: r = (b == 0) ? ONES : a / b;
        OP_REM:
          if (b == 0) r = a;
          else if (a == MIN64 && b == ONES) r = '0;
          else r = $signed(a) % $signed(b);
        OP_REMU: r = (b == 0) ? a : a % b;
        default: r = p[127:64];
      endcase
    end
    return r;
  endfunction

  // Cycle (counting the accept cycle as 0) in which o_mdu_valid first shows.
  function automatic int ref_lat(input logic [2:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic [63:0] aw, bw, mn, m1;
    aw = w ? {32'b0, a[31:0]} : a;
    bw = w ? {32'b0, b[31:0]} : b;
    mn = w ? 64'h8000_0000 : MIN64;
    m1 = w ? 64'hFFFF_FFFF : ONES;
    if (op[2] && (bw == 0 || (!op[0] && aw == mn && bw == m1))) return 2;
    return (w ? 32 : 64) + 3;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = ONES;
      2: v = MIN64;
      3: v = 64'hFFFF_FFFF_8000_0000;
      4: v = 64'($urandom_range(0, 20));
      5: v = -64'($urandom_range(1, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic issue(input string tag, input logic [2:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b, output int cyc);
    @(negedge clk);
    chk({tag, "/rdy_idle"}, 64'(o_ready), 64'd1);
    valid_i = 1'b1; op_i = op; word_i = w; a_i = a; b_i = b;
    @(negedge clk);
    valid_i = 1'b0; op_i = 3'($urandom); word_i = 1'($urandom);
    a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom};
    chk({tag, "/rdy_busy"}, 64'(o_ready), 64'd0);
    cyc = 1;
    while (o_valid !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat);
    int cyc;
    issue(tag, op, w, a, b, cyc);
    chk({tag, "/latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "/result"}, o_result, exp_res);
    rdy_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0;
    chk({tag, "/consumed"}, 64'(o_valid), 64'd0);
  endtask

  initial begin
    int cyc;
    logic seen;
    logic [2:0] rop;
    logic rw;
    logic [63:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_result", o_result, 64'd0);
    rstn = 1'b1;
    #1 chk("rst_ready", 64'(o_ready), 64'd1);

    run_op("mul_7x6", OP_MUL, 1'b0, 64'd7, 64'd6, 64'h2A, 67);
    run_op("mulh_m1m1", OP_MULH, 1'b0, ONES, ONES, 64'd0, 67);
    run_op("mulhu_max2", OP_MULHU, 1'b0, ONES, 64'd2, 64'd1, 67);
    run_op("mulhsu_m1_2", OP_MULHSU, 1'b0, ONES, 64'd2, ONES, 67);
    run_op("div_m7_2", OP_DIV, 1'b0, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67);
    run_op("rem_m7_2", OP_REM, 1'b0, -64'd7, 64'd2, ONES, 67);
    run_op("divw_ovf", OP_DIV, 1'b1, 64'h8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 2);
    run_op("divu_by0", OP_DIVU, 1'b0, 64'h55, 64'd0, ONES, 2);
    run_op("remu_by0", OP_REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 2);
    run_op("rem_ovf", OP_REM, 1'b0, MIN64, ONES, 64'd0, 2);
    run_op("mulw_neg", OP_MUL, 1'b1, 64'h0000_0001_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 35);

    // Result held in DONE with consumer stalled, then flush and ready together.
    issue("hold", OP_MUL, 1'b0, 64'd123, 64'd456, cyc);
    chk("hold/latency", 64'(cyc), 64'd67);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold/valid", 64'(o_valid), 64'd1);
      chk("hold/result", o_result, 64'd56088);
      chk("hold/ready", 64'(o_ready), 64'd0);
    end
    rdy_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("done_flush/valid", 64'(o_valid), 64'd0);
    chk("done_flush/ready", 64'(o_ready), 64'd1);

    // Flush in the fifth CALC cycle, then a fresh request.
    @(negedge clk);
    valid_i = 1'b1; op_i = OP_MUL; word_i = 1'b0; a_i = 64'd3; b_i = 64'd5;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("calc_flush/valid", 64'(o_valid), 64'd0);
    chk("calc_flush/ready", 64'(o_ready), 64'd1);
    run_op("after_flush", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 67);

    // Request and flush in the same cycle must not be accepted.
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU; a_i = 64'd9; b_i = 64'd0;
    #1 chk("flush_req/ready", 64'(o_ready), 64'd0);
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    #1 chk("flush_req/idle", 64'(o_ready), 64'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | o_valid;
    end
    chk("flush_req/no_valid", 64'(seen), 64'd0);

    // Reset pulse during CALC aborts with no output afterwards.
    @(negedge clk);
    valid_i = 1'b1; op_i = OP_MUL; word_i = 1'b0; a_i = 64'd11; b_i = 64'd13;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst/valid", 64'(o_valid), 64'd0);
    chk("mid_rst/result", o_result, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      seen = seen | o_valid;
    end
    chk("mid_rst/no_valid", 64'(seen), 64'd0);
    chk("mid_rst/ready", 64'(o_ready), 64'd1);

    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      rw  = ($urandom_range(0, 2) == 0);
      if (rw && !rop[2]) rop = OP_MUL;
      ra  = pick();
      rb  = pick();
      run_op($sformatf("rnd%0d_op%0d_w%0d", n, rop, rw), rop, rw, ra, rb,
             ref_mdu(rop, rw, ra, rb), ref_lat(rop, rw, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
